// File: rtl/nibble_collector_pkg.sv
// rtl/nibble_collector_pkg.sv - shared types and constants for the nibble collector
package nibble_collector_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} nc_state_t;

  localparam int NC_DEFAULT_W = 4;

  // Counter width for a W-bit word; never narrower than one bit
  function automatic int nc_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/nc_shifter.sv
// rtl/nc_shifter.sv - W-bit serial shift register with direction select and synchronous clear
module nc_shifter #(
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] q_next
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_base;

  // Next register value; clr together with shift_en starts a fresh word holding only bit_in
  always_comb begin
    w_base = clr ? '0 : r_q;
    q_next = r_q;
    if (shift_en) begin
      if (MSB_FIRST) q_next = {w_base[W-2:0], bit_in};
      else           q_next = {bit_in, w_base[W-1:1]};
    end else if (clr) begin
      q_next = '0;
    end
  end

  // Shift register storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_q <= '0;
    else        r_q <= q_next;
  end

endmodule

// File: rtl/nibble_collector.sv
// rtl/nibble_collector.sv - framed serial-to-parallel word collector; NIBBLE_COLLECTOR_PARITY_EN adds an even-parity bit per word
module nibble_collector
  import nibble_collector_pkg::*;
#(
  parameter int W         = NC_DEFAULT_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         frame,
  output logic [W-1:0] d,
  output logic         en,
  output logic         busy,
  output logic         err
);

  localparam int             CW   = nc_cnt_w(W);
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  nc_state_t     r_state;
  nc_state_t     w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [W-1:0]  r_d;
  logic [W-1:0]  w_d_next;
  logic          r_en;
  logic          w_en_next;
  logic          r_err;
  logic          w_err_next;
  logic          r_busy;
  logic          w_clr;
  logic          w_shift;
  logic [W-1:0]  w_sr_next;
  logic          w_framed;
  logic          w_data;

  assign w_framed = sin_valid & frame;
  assign w_data   = sin_valid & ~frame;

  nc_shifter #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_clr),
    .shift_en (w_shift),
    .bit_in   (sin),
    .q_next   (w_sr_next)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: a framed bit always (re)starts a word; the last bit returns to IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_framed) w_state_next = SHIFT;
      end
      SHIFT: begin
        if (w_framed) begin
          w_state_next = SHIFT;
        end else if (w_data && (r_cnt == LAST)) begin
`ifdef NIBBLE_COLLECTOR_PARITY_EN
          w_state_next = PAR;
`else
          w_state_next = IDLE;
`endif
        end
      end
`ifdef NIBBLE_COLLECTOR_PARITY_EN
      PAR: begin
        if (w_framed)    w_state_next = SHIFT;
        else if (w_data) w_state_next = IDLE;
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath controls and next values of the registered outputs
  always_comb begin
    w_clr      = 1'b0;
    w_shift    = 1'b0;
    w_cnt_next = r_cnt;
    w_d_next   = r_d;
    w_en_next  = 1'b0;
    w_err_next = 1'b0;
    if (w_framed) begin
      // A framed bit outside IDLE aborts the partial word; it still seeds the new one
      w_clr      = 1'b1;
      w_shift    = 1'b1;
      w_cnt_next = CW'(1);
      w_err_next = (r_state != IDLE);
    end else if (w_data) begin
      case (r_state)
        SHIFT: begin
          w_shift = 1'b1;
          if (r_cnt == LAST) begin
            w_cnt_next = '0;
`ifndef NIBBLE_COLLECTOR_PARITY_EN
            w_en_next  = 1'b1;
            w_d_next   = w_sr_next;
`endif
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
`ifdef NIBBLE_COLLECTOR_PARITY_EN
        PAR: begin
          // Shifter is idle here, so its next value is the completed word
          w_cnt_next = '0;
          if (sin == ^w_sr_next) begin
            w_en_next = 1'b1;
            w_d_next  = w_sr_next;
          end else begin
            w_err_next = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Registered outputs and bit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_d    <= '0;
      r_en   <= 1'b0;
      r_err  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_d    <= w_d_next;
      r_en   <= w_en_next;
      r_err  <= w_err_next;
      r_busy <= (w_state_next != IDLE);
    end
  end

  assign d    = r_d;
  assign en   = r_en;
  assign err  = r_err;
  assign busy = r_busy;

endmodule

// File: tb/tb_nibble_collector.sv
// tb/tb_nibble_collector.sv - self-checking bench for nibble_collector (MSB-first and LSB-first instances)
module tb_nibble_collector;

  localparam int W = 4;
`ifdef NIBBLE_COLLECTOR_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         sin;
  logic         sin_valid;
  logic         frame;
  logic [W-1:0] d_m, d_l;
  logic         en_m, en_l, err_m, err_l, busy_m, busy_l;

  int n_vec  = 0;
  int n_fail = 0;
  int n_en_m = 0;
  int n_err_m = 0;
  int n_busy_m = 0;

  // Reference model: bits of the word being collected, in arrival order
  int           bits[$];
  bit           active;
  logic [W-1:0] exp_dm, exp_dl;
  logic         exp_en, exp_err;

  always #5 clk = ~clk;

  nibble_collector #(.W(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .frame(frame),
    .d(d_m), .en(en_m), .busy(busy_m), .err(err_m)
  );

  nibble_collector #(.W(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .frame(frame),
    .d(d_l), .en(en_l), .busy(busy_l), .err(err_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    active  = 1'b0;
    exp_dm  = '0;
    exp_dl  = '0;
    exp_en  = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic finish_word();
    int vm, vl;
    vm = 0;
    vl = 0;
    for (int i = 0; i < W; i++) begin
      vm += bits[i] * (1 << (W - 1 - i));
      vl += bits[i] * (1 << i);
    end
    exp_dm = W'(vm);
    exp_dl = W'(vl);
    exp_en = 1'b1;
    active = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic f, input logic b);
    int par;
    exp_en  = 1'b0;
    exp_err = 1'b0;
    if (v) begin
      if (f) begin
        exp_err = active;
        bits.delete();
        bits.push_back(int'(b));
        active = 1'b1;
      end else if (active) begin
        if (bits.size() < W) begin
          bits.push_back(int'(b));
          if (bits.size() == W && !PAR_EN) finish_word();
        end else begin
          par = 0;
          foreach (bits[i]) par ^= bits[i];
          if (int'(b) == par) finish_word();
          else exp_err = 1'b1;
          active = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("en_msb",   en_m,   exp_en);
    chk("en_lsb",   en_l,   exp_en);
    chk("err_msb",  err_m,  exp_err);
    chk("err_lsb",  err_l,  exp_err);
    chk("busy_msb", busy_m, active);
    chk("busy_lsb", busy_l, active);
    chk("d_msb",    d_m,    exp_dm);
    chk("d_lsb",    d_l,    exp_dl);
  endtask

  task automatic step(input logic v, input logic f, input logic b);
    sin_valid = v;
    frame     = f;
    sin       = b;
    @(posedge clk);
    model_step(v, f, b);
    #1;
    n_en_m   += int'(en_m);
    n_err_m  += int'(err_m);
    n_busy_m += int'(busy_m);
    check_all();
  endtask

  // Sends one word, first bit taken from w[W-1]; adds a parity bit in parity builds
  task automatic send_word(input logic [W-1:0] w, input int gap, input bit good_par);
    for (int i = 0; i < W; i++) begin
      if (i > 0) repeat (gap) step(1'b0, 1'($urandom), 1'($urandom));
      step(1'b1, (i == 0), w[W-1-i]);
    end
    if (PAR_EN) begin
      repeat (gap) step(1'b0, 1'($urandom), 1'($urandom));
      step(1'b1, 1'b0, (^w) ^ !good_par);
    end
  endtask

  initial begin
    int e0, r0, b0;
    reset     = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b0;
    frame     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Back-to-back word 1011
    e0 = n_en_m; b0 = n_busy_m;
    send_word(4'b1011, 0, 1'b1);
    chk("s1_d", d_m, 4'b1011);
    chk("s1_en_count", n_en_m - e0, 1);
    chk("s1_busy_cycles", n_busy_m - b0, W - 1 + int'(PAR_EN));
    step(1'b0, 1'b0, 1'b0);

    // Same word with 2-cycle gaps, then unframed bits while idle
    e0 = n_en_m;
    send_word(4'b1011, 2, 1'b1);
    chk("s2_d", d_m, 4'b1011);
    chk("s2_en_count", n_en_m - e0, 1);
    e0 = n_en_m;
    repeat (5) step(1'b1, 1'b0, 1'($urandom));
    chk("s2_idle_en", n_en_m - e0, 0);
    chk("s2_idle_busy", busy_m, 1'b0);

    // Abort after two bits, then a full word 0001
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    e0 = n_en_m; r0 = n_err_m;
    send_word(4'b0001, 0, 1'b1);
    chk("s3_d", d_m, 4'b0001);
    chk("s3_en_count", n_en_m - e0, 1);
    chk("s3_err_count", n_err_m - r0, 1);

    // LSB-first word, then reset after two bits of the next word
    send_word(4'b1000, 0, 1'b1);
    chk("s4_d_lsb", d_l, 4'b0001);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
    e0 = n_en_m; r0 = n_err_m;
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("s4_post_reset_en", n_en_m - e0, 0);
    chk("s4_post_reset_err", n_err_m - r0, 0);

`ifdef NIBBLE_COLLECTOR_PARITY_EN
    // Good parity loads; bad parity flags an error and keeps the old word
    e0 = n_en_m;
    send_word(4'b1011, 0, 1'b1);
    chk("s5_d", d_m, 4'b1011);
    chk("s5_en_count", n_en_m - e0, 1);
    e0 = n_en_m; r0 = n_err_m;
    send_word(4'b1011, 0, 1'b0);
    chk("s6_en_count", n_en_m - e0, 0);
    chk("s6_err_count", n_err_m - r0, 1);
    chk("s6_d_hold", d_m, 4'b1011);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      step(1'(($urandom % 4) != 0), 1'(($urandom % 6) == 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
